demux_stream_router: RTL and testbench
======================================

Name: demux_stream_router

Overview:
- Parametrised, registered successor to the 8-way combinational demultiplexer.
- Routes a valid/ready input stream to one of NUM_OUT output channels (unicast), or to all of them (broadcast).
- Holds each word in a one-entry stage until every addressed channel has accepted it.
- Drops and counts words whose select is out of range; sits between a producer and NUM_OUT independent consumers in the lab datapath.

Parameters:
- NUM_OUT, 8, number of output channels (2..16; need not be a power of two).
- WIDTH, 8, data word width in bits.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_OUT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  SEL_W  destination channel index (unicast).
- in_bcast  input  1  1 = broadcast to all channels, in_sel ignored.
- in_valid  input  1  producer offers word.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  held word, shared by all channels.
- out_valid  output  NUM_OUT  bit i = word pending for channel i.
- out_ready  input  NUM_OUT  bit i = channel i accepts.
- busy  output  1  a word is held (pending mask non-zero).
- err_count  output  8  saturating count of dropped out-of-range words.

Behaviour:
- State: pending[NUM_OUT-1:0] register, data register, err_count register.
  - EMPTY: pending==0.
  - HOLD: pending!=0.
- Reset (async, any time, including mid-transfer): pending=0, data=0, err_count=0. Hence out_valid=0, busy=0, out_data=0; any held word is discarded.
- Per-lane signals:
  - out_valid = pending.
  - busy = |pending.
  - out_data = data register.
  - done[i] = pending[i] & out_ready[i].
  - remaining = pending & ~done.
- in_ready = (remaining == 0), combinational. Gives full throughput: a new word is accepted in the same cycle the last pending lane completes.
- Accept = in_valid & in_ready. On the accepting edge:
  - in_bcast=1: data<=in_data; pending<=all ones.
  - in_bcast=0 and in_sel<NUM_OUT: data<=in_data; pending<=one-hot(in_sel).
  - in_bcast=0 and in_sel>=NUM_OUT: word dropped; pending<=0, data unchanged; err_count<=err_count+1, saturating at 255 (stays 255).
- No accept: pending<=remaining; data unchanged.
- Latency: accept at edge k gives out_valid visible after edge k, i.e. 1 cycle. No combinational in-to-out data path.
- Broadcast completion: lanes may accept on different cycles. Each lane clears independently and never sees the word twice. The word retires when the last lane clears.
- out_ready[i] while pending[i]=0 has no effect.
- in_data/in_sel/in_bcast are sampled only on accept; changes during HOLD do not affect the held word.
- in_valid low: state unchanged apart from lane completion.
- Out-of-range drop while EMPTY still asserts in_ready (drop consumes the word in one cycle).

Test Plan (NUM_OUT=5, WIDTH=8, SEL_W=3):
- Reset asserted mid-HOLD (pending=5'b00100) -> out_valid=0, busy=0, out_data=0, err_count=0 immediately, without waiting for a clock edge.
- Unicast 0xA5 sel=3, out_ready=all 1 -> out_valid=5'b01000 one cycle later, retires next edge; back-to-back 0x5A sel=0 accepted in that same cycle; in_ready stays 1 throughout.
- Unicast 0x3C sel=1 with out_ready=0 for 4 cycles -> out_valid=5'b00010 and out_data=0x3C held; in_ready=0; in_data changed to 0xFF during hold is ignored; release -> retires.
- Broadcast 0x77, lanes ready one per cycle in order 4,2,0,1,3 -> out_valid steps 11111→01111→01011→01010→01000→00000; in_ready=1 only in the final cycle.
- sel=5,6,7 unicast, three words -> dropped, no out_valid, err_count=3; then 260 total bad words -> err_count=255 saturated.
- Broadcast accepted with in_sel=7 -> treated as broadcast, err_count unchanged.

Source files
------------

// File: rtl/demux_stream_router.sv
// Registered valid/ready demultiplexer: routes each word to one channel or broadcasts it to all,
// holding it in a one-entry stage until every addressed channel has taken it.
module demux_stream_router #(
    parameter int NUM_OUT = 8,
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               busy,
    output logic [7:0]         err_count
);

    localparam logic [SEL_W:0] NUM_OUT_W = NUM_OUT[SEL_W:0];

    logic [NUM_OUT-1:0] r_pending;
    logic [WIDTH-1:0]   r_data;
    logic [7:0]         r_errCount;

    logic [NUM_OUT-1:0] w_done;
    logic [NUM_OUT-1:0] w_remaining;
    logic [NUM_OUT-1:0] w_oneHot;
    logic               w_inRange;
    logic               w_accept;

    assign w_done      = r_pending & out_ready;
    assign w_remaining = r_pending & ~w_done;
    assign w_inRange   = ({1'b0, in_sel} < NUM_OUT_W);
    assign w_oneHot    = {{(NUM_OUT-1){1'b0}}, 1'b1} << in_sel;

    // A new word may enter in the same cycle the last pending lane completes.
    assign in_ready = (w_remaining == '0);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_data     <= '0;
            r_errCount <= '0;
        end else if (w_accept) begin
            if (in_bcast) begin
                r_data    <= in_data;
                r_pending <= '1;
            end else if (w_inRange) begin
                r_data    <= in_data;
                r_pending <= w_oneHot;
            end else begin
                // Out-of-range select: the word is consumed and discarded, only the counter moves.
                r_pending <= '0;
                if (r_errCount != 8'hFF) begin
                    r_errCount <= r_errCount + 8'd1;
                end
            end
        end else begin
            r_pending <= w_remaining;
        end
    end

    assign out_valid = r_pending;
    assign out_data  = r_data;
    assign busy      = |r_pending;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_demux_stream_router.sv
// Directed-vector bench for demux_stream_router with five channels: a per-cycle vector table
// plus hand-written sequences for error-counter saturation and asynchronous reset during a hold.
module tb_demux_stream_router;

    logic       clk;
    logic       reset;
    logic [7:0] inData;
    logic [2:0] inSel;
    logic       inBcast;
    logic       inValid;
    logic       inReady;
    logic [7:0] outData;
    logic [4:0] outValid;
    logic [4:0] outReady;
    logic       busy;
    logic [7:0] errCount;

    int vectorsApplied = 0;
    int miscompares    = 0;

    typedef struct {
        logic       valid;
        logic       bcast;
        logic [2:0] sel;
        logic [7:0] data;
        logic [4:0] ready;
        logic       expInReady;
        logic [4:0] expValid;
        logic [7:0] expData;
        logic [7:0] expErr;
    } vec_t;

    vec_t vecs [25];

    demux_stream_router #(.NUM_OUT(5), .WIDTH(8), .SEL_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (inData),
        .in_sel    (inSel),
        .in_bcast  (inBcast),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out_data  (outData),
        .out_valid (outValid),
        .out_ready (outReady),
        .busy      (busy),
        .err_count (errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic b, input logic [2:0] s, input logic [7:0] d,
                                input logic [4:0] r, input logic eir, input logic [4:0] ev,
                                input logic [7:0] ed, input logic [7:0] ee);
        vec_t t;
        t.valid = v; t.bcast = b; t.sel = s; t.data = d; t.ready = r;
        t.expInReady = eir; t.expValid = ev; t.expData = ed; t.expErr = ee;
        return t;
    endfunction

    // Drive one cycle's inputs just after the falling edge, well away from the sampling edge.
    task automatic applyStimulus(input logic v, input logic b, input logic [2:0] s,
                                 input logic [7:0] d, input logic [4:0] r);
        @(negedge clk);
        inValid  = v;
        inBcast  = b;
        inSel    = s;
        inData   = d;
        outReady = r;
        #1;
    endtask

    // Compares all observable outputs; busy is expected whenever any lane is pending.
    task automatic checkOutput(input string name, input logic expInReady, input logic [4:0] expValid,
                               input logic [7:0] expData, input logic [7:0] expErr);
        logic expBusy;
        expBusy = (expValid != 5'b0);
        vectorsApplied++;
        if (inReady !== expInReady) begin
            miscompares++;
            $display("[TB] FAIL %s in_ready: got %b expected %b", name, inReady, expInReady);
        end
        if (outValid !== expValid) begin
            miscompares++;
            $display("[TB] FAIL %s out_valid: got %b expected %b", name, outValid, expValid);
        end
        if (outData !== expData) begin
            miscompares++;
            $display("[TB] FAIL %s out_data: got %h expected %h", name, outData, expData);
        end
        if (busy !== expBusy) begin
            miscompares++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, busy, expBusy);
        end
        if (errCount !== expErr) begin
            miscompares++;
            $display("[TB] FAIL %s err_count: got %0d expected %0d", name, errCount, expErr);
        end
    endtask

    initial begin
        // Expected columns describe the cycle before the edge at which the inputs are sampled.
        //               vld bc sel  data   ready     inRdy valid     data   err
        vecs[0]  = mk(0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h00, 8'd0);
        vecs[1]  = mk(1, 0, 3'd3, 8'hA5, 5'b11111, 1, 5'b00000, 8'h00, 8'd0);
        vecs[2]  = mk(1, 0, 3'd0, 8'h5A, 5'b11111, 1, 5'b01000, 8'hA5, 8'd0);
        vecs[3]  = mk(0, 0, 3'd0, 8'h00, 5'b11111, 1, 5'b00001, 8'h5A, 8'd0);
        vecs[4]  = mk(1, 0, 3'd1, 8'h3C, 5'b00000, 1, 5'b00000, 8'h5A, 8'd0);
        vecs[5]  = mk(1, 0, 3'd1, 8'hFF, 5'b00000, 0, 5'b00010, 8'h3C, 8'd0);
        vecs[6]  = mk(1, 0, 3'd1, 8'hFF, 5'b00000, 0, 5'b00010, 8'h3C, 8'd0);
        vecs[7]  = mk(1, 0, 3'd1, 8'hFF, 5'b11101, 0, 5'b00010, 8'h3C, 8'd0);
        vecs[8]  = mk(1, 0, 3'd1, 8'hFF, 5'b00000, 0, 5'b00010, 8'h3C, 8'd0);
        vecs[9]  = mk(0, 0, 3'd1, 8'hFF, 5'b00010, 1, 5'b00010, 8'h3C, 8'd0);
        vecs[10] = mk(0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h3C, 8'd0);
        vecs[11] = mk(1, 1, 3'd0, 8'h77, 5'b00000, 1, 5'b00000, 8'h3C, 8'd0);
        vecs[12] = mk(0, 0, 3'd0, 8'h00, 5'b10000, 0, 5'b11111, 8'h77, 8'd0);
        vecs[13] = mk(0, 0, 3'd0, 8'h00, 5'b10100, 0, 5'b01111, 8'h77, 8'd0);
        vecs[14] = mk(0, 0, 3'd0, 8'h00, 5'b00001, 0, 5'b01011, 8'h77, 8'd0);
        vecs[15] = mk(0, 0, 3'd0, 8'h00, 5'b00010, 0, 5'b01010, 8'h77, 8'd0);
        vecs[16] = mk(0, 0, 3'd0, 8'h00, 5'b01000, 1, 5'b01000, 8'h77, 8'd0);
        vecs[17] = mk(0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h77, 8'd0);
        vecs[18] = mk(1, 0, 3'd5, 8'h11, 5'b00000, 1, 5'b00000, 8'h77, 8'd0);
        vecs[19] = mk(1, 0, 3'd6, 8'h22, 5'b00000, 1, 5'b00000, 8'h77, 8'd1);
        vecs[20] = mk(1, 0, 3'd7, 8'h33, 5'b00000, 1, 5'b00000, 8'h77, 8'd2);
        vecs[21] = mk(0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h77, 8'd3);
        vecs[22] = mk(1, 1, 3'd7, 8'h99, 5'b11111, 1, 5'b00000, 8'h77, 8'd3);
        vecs[23] = mk(0, 0, 3'd0, 8'h00, 5'b11111, 1, 5'b11111, 8'h99, 8'd3);
        vecs[24] = mk(0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h99, 8'd3);

        reset    = 1'b1;
        inData   = 8'h00;
        inSel    = 3'd0;
        inBcast  = 1'b0;
        inValid  = 1'b0;
        outReady = 5'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_state", 1'b1, 5'b00000, 8'h00, 8'd0);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].bcast, vecs[i].sel, vecs[i].data, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].expInReady, vecs[i].expValid,
                        vecs[i].expData, vecs[i].expErr);
        end

        // 257 more bad selects on top of the 3 already dropped: the counter must stop at 255.
        for (int i = 0; i < 257; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd5, 8'hEE, 5'b00000);
            if (i == 251) checkOutput("err_254", 1'b1, 5'b00000, 8'h99, 8'd254);
            if (i == 252) checkOutput("err_255", 1'b1, 5'b00000, 8'h99, 8'd255);
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 5'b00000);
        checkOutput("err_saturated", 1'b1, 5'b00000, 8'h99, 8'd255);

        // Asynchronous reset in the middle of a hold on lane 2.
        applyStimulus(1'b1, 1'b0, 3'd2, 8'h44, 5'b00000);
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 5'b00000);
        checkOutput("hold_lane2", 1'b0, 5'b00100, 8'h44, 8'd255);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset", 1'b1, 5'b00000, 8'h00, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 5'b11111);
        checkOutput("after_reset", 1'b1, 5'b00000, 8'h00, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
